// File: rtl/counter_seq_checker.sv
// Read-side sequence checker for the counter-to-FIFO path: pops words, verifies
// each is the previous word plus one (mod 2^DATA_W), keeps counts and the first mismatch.
module counter_seq_checker #(
  parameter int DATA_W = 20,
  parameter int CNT_W  = 32,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              busy,
  output logic              locked,
  output logic              err_flag,
  output logic [CNT_W-1:0]  words_checked,
  output logic [ERR_W-1:0]  err_count,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  // state | meaning
  // IDLE  | not checking; statistics hold
  // SYNC  | reading, waiting for the seed word
  // CHECK | reading, comparing each word against expected
  // DRAIN | reads stopped; absorb any outstanding word, then IDLE
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CHECK, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   expected_q, expected_d;
  logic                locked_q, locked_d;
  logic                err_flag_q, err_flag_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0]   fe_exp_q, fe_exp_d;
  logic [DATA_W-1:0]   fe_got_q, fe_got_d;
  logic                reading;
  logic                seed;
  logic                check;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    locked_d   = locked_q;
    err_flag_d = err_flag_q;
    words_d    = words_q;
    err_cnt_d  = err_cnt_q;
    fe_exp_d   = fe_exp_q;
    fe_got_d   = fe_got_q;

    reading    = (state_q == S_SYNC) || (state_q == S_CHECK);
    // stop cuts the read strobe immediately unless start overrides it
    fifo_rd_en = reading && !fifo_empty && !(stop && !start);
    rvalid_d   = fifo_rd_en;

    // in DRAIN, locked tells which state the outstanding word belongs to
    seed  = rvalid_q && ((state_q == S_SYNC)  || ((state_q == S_DRAIN) && !locked_q));
    check = rvalid_q && ((state_q == S_CHECK) || ((state_q == S_DRAIN) &&  locked_q));

    if (start) begin
      state_d    = S_SYNC;
      expected_d = '0;
      locked_d   = 1'b0;
      err_flag_d = 1'b0;
      words_d    = '0;
      err_cnt_d  = '0;
      fe_exp_d   = '0;
      fe_got_d   = '0;
    end else begin
      if (seed) begin
        expected_d = fifo_rdata + DATA_W'(1);
        locked_d   = 1'b1;
        words_d    = words_q + CNT_W'(1);
      end
      if (check) begin
        expected_d = fifo_rdata + DATA_W'(1);
        words_d    = words_q + CNT_W'(1);
        if (fifo_rdata != expected_q) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          if (!err_flag_q) begin
            err_flag_d = 1'b1;
            fe_exp_d   = expected_q;
            fe_got_d   = fifo_rdata;
          end
        end
      end
      case (state_q)
        S_SYNC: begin
          if (seed) state_d = S_CHECK;
          if (stop) state_d = S_DRAIN;
        end
        S_CHECK: if (stop) state_d = S_DRAIN;
        S_DRAIN: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rvalid_q   <= 1'b0;
      expected_q <= '0;
      locked_q   <= 1'b0;
      err_flag_q <= 1'b0;
      words_q    <= '0;
      err_cnt_q  <= '0;
      fe_exp_q   <= '0;
      fe_got_q   <= '0;
    end else begin
      state_q    <= state_d;
      rvalid_q   <= start ? 1'b0 : rvalid_d;
      expected_q <= expected_d;
      locked_q   <= locked_d;
      err_flag_q <= err_flag_d;
      words_q    <= words_d;
      err_cnt_q  <= err_cnt_d;
      fe_exp_q   <= fe_exp_d;
      fe_got_q   <= fe_got_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign locked        = locked_q;
  assign err_flag      = err_flag_q;
  assign words_checked = words_q;
  assign err_count     = err_cnt_q;
  assign first_err_exp = fe_exp_q;
  assign first_err_got = fe_got_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench for counter_seq_checker: queue-based FIFO model, directed and random word
// streams, expectations recomputed from the word list actually delivered.
module tb_counter_seq_checker;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [19:0] fifo_rdata = '0;
  logic        busy, locked, err_flag;
  logic [31:0] words_checked;
  logic [15:0] err_count;
  logic [19:0] first_err_exp, first_err_got;

  counter_seq_checker dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata),
    .busy(busy), .locked(locked), .err_flag(err_flag),
    .words_checked(words_checked), .err_count(err_count),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  logic [19:0] fq[$];
  logic [19:0] sent[$];
  int          evals = 0;
  int          fails = 0;
  int          cyc = 0;
  int          bad_rd = 0;
  int          gaps = 0;
  bit          force_ne = 1'b0;
  bit          toggle_empty = 1'b0;
  logic        rd_seen;

  int          m_wc, m_ec;
  logic [19:0] m_fe, m_fg;
  logic        m_ef;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, model FIFO pop at posedge
  task automatic cycle(input logic s_start, input logic s_stop);
    @(negedge clk);
    start = s_start;
    stop  = s_stop;
    if (s_start) sent.delete();
    fifo_empty = ((fq.size() == 0) && !force_ne) || (toggle_empty && cyc[0]);
    @(posedge clk);
    cyc++;
    rd_seen = fifo_rd_en;
    if (fifo_rd_en && fifo_empty) bad_rd++;
    if (busy && !fifo_empty && !fifo_rd_en && !s_stop) gaps++;
    #1;
    start = 1'b0;
    stop  = 1'b0;
    if (rd_seen) begin
      if (fq.size() != 0) begin
        fifo_rdata = fq.pop_front();
        sent.push_back(fifo_rdata);
      end else begin
        fifo_rdata = '0;
      end
    end
  endtask

  // Expected statistics straight from the delivered word list
  task automatic model();
    logic [19:0] e;
    m_wc = sent.size();
    m_ec = 0;
    m_ef = 1'b0;
    m_fe = '0;
    m_fg = '0;
    if (sent.size() != 0) e = sent[0] + 20'd1;
    for (int i = 1; i < sent.size(); i++) begin
      if (sent[i] != e) begin
        if (m_ec < 65535) m_ec++;
        if (!m_ef) begin
          m_ef = 1'b1;
          m_fe = e;
          m_fg = sent[i];
        end
      end
      e = sent[i] + 20'd1;
    end
  endtask

  task automatic feed(input string tag, input int budget);
    int n = 0;
    while (fq.size() != 0 && n < budget) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  task automatic check_stats(input string tag);
    model();
    chk({tag, "_words"}, words_checked, 32'(m_wc));
    chk({tag, "_errs"}, 32'(err_count), 32'(m_ec));
    chk({tag, "_eflag"}, 32'(err_flag), 32'(m_ef));
    chk({tag, "_fexp"}, 32'(first_err_exp), 32'(m_fe));
    chk({tag, "_fgot"}, 32'(first_err_got), 32'(m_fg));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd"}, 32'(fifo_rd_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_eflag"}, 32'(err_flag), 32'd0);
    chk({tag, "_words"}, words_checked, 32'd0);
    chk({tag, "_errs"}, 32'(err_count), 32'd0);
    chk({tag, "_fexp"}, 32'(first_err_exp), 32'd0);
    chk({tag, "_fgot"}, 32'(first_err_got), 32'd0);
  endtask

  task automatic run_list(input string tag);
    cycle(1'b1, 1'b0);
    feed(tag, 2000);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd1);
    check_stats(tag);
  endtask

  initial begin
    logic [19:0] w;

    // reset with a non-empty FIFO and no start
    force_ne = 1'b1;
    rstn = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_zero("reset");
    rstn = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_zero("post_reset_idle");
    force_ne = 1'b0;

    // 256 consecutive words back to back
    for (int i = 0; i < 256; i++) fq.push_back(20'h00010 + 20'(i));
    gaps = 0;
    run_list("incr256");
    chk("incr256_nwords", words_checked, 32'd256);
    chk("incr256_gaps", 32'(gaps), 32'd0);

    // wrap-around is not an error
    fq = '{20'hFFFFD, 20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    run_list("wrap");
    chk("wrap_nerr", 32'(err_count), 32'd0);

    // skipped and repeated word, first error captured
    fq = '{20'd5, 20'd6, 20'd8, 20'd9, 20'd9, 20'd10};
    run_list("skip");
    chk("skip_nerr", 32'(err_count), 32'd2);
    chk("skip_fexp7", 32'(first_err_exp), 32'd7);
    chk("skip_fgot8", 32'(first_err_got), 32'd8);

    // random stream with empty toggling; stop the cycle after the 100th read
    w = 20'($urandom);
    for (int i = 0; i < 104; i++) begin
      if (i == 50) w = w + 20'd5;
      else if ($urandom_range(0, 9) == 0) w = 20'($urandom_range(0, 20'hFFFFF));
      else w = w + 20'd1;
      fq.push_back(w);
    end
    toggle_empty = 1'b1;
    cycle(1'b1, 1'b0);
    begin
      int n = 0;
      while (sent.size() < 100 && n < 1000) begin
        cycle(1'b0, 1'b0);
        n++;
      end
      chk("rand_timeout", 32'(n < 1000), 32'd1);
    end
    cycle(1'b0, 1'b1);
    chk("rand_stop_rd", 32'(rd_seen), 32'd0);
    cycle(1'b0, 1'b0);
    chk("rand_drain_rd", 32'(rd_seen), 32'd0);
    cycle(1'b0, 1'b0);
    chk("rand_idle", 32'(busy), 32'd0);
    chk("rand_nwords", words_checked, 32'd100);
    check_stats("rand");
    toggle_empty = 1'b0;
    fq.delete();
    cycle(1'b0, 1'b0);

    // reset in the middle of CHECK with three errors
    fq = '{20'd1, 20'd2, 20'd9, 20'd4, 20'd5, 20'd6, 20'd100};
    cycle(1'b1, 1'b0);
    feed("midrst", 200);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_nerr", 32'(err_count), 32'd3);
    check_stats("midrst");
    rstn = 1'b0;
    cycle(1'b0, 1'b0);
    rstn = 1'b1;
    check_zero("midrst_after");

    // restart while checking with err_flag set
    fq = '{20'd7, 20'd8, 20'd1, 20'd2};
    cycle(1'b1, 1'b0);
    feed("restart_pre", 200);
    chk("restart_pre_eflag", 32'(err_flag), 32'd1);
    cycle(1'b1, 1'b0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_locked", 32'(locked), 32'd0);
    chk("restart_words", words_checked, 32'd0);
    chk("restart_errs", 32'(err_count), 32'd0);
    chk("restart_eflag", 32'(err_flag), 32'd0);
    chk("restart_fexp", 32'(first_err_exp), 32'd0);
    cycle(1'b0, 1'b0);
    chk("restart_still_unlocked", 32'(locked), 32'd0);
    fq.push_back(20'd42);
    feed("restart_seed", 50);
    chk("restart_seed_locked", 32'(locked), 32'd1);
    chk("restart_seed_words", words_checked, 32'd1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("restart_idle", 32'(busy), 32'd0);

    chk("rd_while_empty", 32'(bad_rd), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
